sram_uart_bus_ctrl: RTL and testbench
=====================================

SRAM_UART_BUS_CTRL -- requirements
Module: sram_uart_bus_ctrl

Interface
REQ-001 Parameter UART_STROBE_CYCLES, default 2; number of cycles uart_rdn/uart_wrn are held low per access.
REQ-002 clk_50M  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_btn  in  1  reset, synchronous, active-high.
REQ-004 req  in  1  access request; held high until ack.
REQ-005 we  in  1  1 = write, 0 = read; sampled with req in IDLE.
REQ-006 addr  in  32  byte address.
REQ-007 wdata  in  32  write data.
REQ-008 be  in  4  byte enables, active-high, bit0 = bits[7:0].
REQ-009 rdata  out  32  read data; valid in the ack cycle.
REQ-010 ack  out  1  one-cycle completion pulse.
REQ-011 base_ram_data  inout  32  base SRAM data; bits[7:0] are shared with the UART.
REQ-012 base_ram_addr  out  20  base SRAM word address.
REQ-013 base_ram_be_n, base_ram_ce_n, base_ram_oe_n, base_ram_we_n  out  4/1/1/1  base SRAM controls, active-low.
REQ-014 ext_ram_data, ext_ram_addr, ext_ram_be_n, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n  same as REQ-011..013  ext SRAM.
REQ-015 uart_rdn, uart_wrn  out  1  UART read/write strobes, active-low.
REQ-016 uart_dataready, uart_tbre, uart_tsre  in  1  UART receive-ready, transmit-buffer-empty and transmit-done flags.

Function
REQ-017 Address map: 0x8000_0000-0x803F_FFFF = base RAM; 0x8040_0000-0x807F_FFFF = ext RAM; 0xBFD0_03F8 = UART data; 0xBFD0_03FC = UART status; any other address is unmapped.
REQ-018 RAM word address = addr[21:2]; RAM byte enables = ~be.
REQ-019 States: IDLE, RAM_RD, RAM_WR, UART_RD, UART_WR, DONE. IDLE with req=1 decodes addr and we and selects the next state.
REQ-020 RAM read: in RAM_RD, for the selected RAM, ce_n=0, oe_n=0, we_n=1, data bus released; data is captured at the end of the 2nd cycle; ack=1 in DONE; latency from req to ack = 3 cycles.
REQ-021 RAM write: data bus driven with wdata for 2 cycles with ce_n=0; we_n is low in the 1st cycle only; oe_n=1; ack=1 in DONE.
REQ-022 The unselected RAM keeps ce_n=1 throughout the access.
REQ-023 UART data read: base_ram_ce_n=1 and base data bus released for the whole access; uart_rdn is held low for UART_STROBE_CYCLES cycles; base_ram_data[7:0] is sampled in the last low cycle; rdata = {24'b0, byte}.
REQ-024 UART data write: base_ram_ce_n=1; base_ram_data[7:0] is driven with wdata[7:0] for UART_STROBE_CYCLES+1 cycles; uart_wrn is low for the first UART_STROBE_CYCLES of those cycles.
REQ-025 UART status read completes in 1 cycle with no strobe; rdata = {30'b0, uart_dataready, uart_tbre & uart_tsre}.
REQ-026 A write to the status address, or any access to an unmapped address, is acknowledged after 1 cycle with no bus activity; rdata = 0.
REQ-027 DONE asserts ack for exactly one cycle, then returns to IDLE; a new req is accepted no earlier than the cycle after ack.
REQ-028 The block drives a data bus only during the write phases defined above; otherwise that bus is high-Z.
REQ-029 uart_rdn and uart_wrn are never low simultaneously; a UART strobe is never low while base_ram_ce_n=0.
REQ-030 rdata holds its last value until the next read completes.

Reset
REQ-031 While reset_btn=1, at the next rising edge: state=IDLE; ack=0; rdata=0; all ce_n/oe_n/we_n=1; be_n=4'hF; uart_rdn=uart_wrn=1; all data buses high-Z.
REQ-032 Reset asserted mid-access aborts the access; no ack is issued; all strobes are high from the next edge.

Verification
REQ-033 Write 0x8000_0004 = 0xDEADBEEF with be=4'hF, then read the same address -> rdata=0xDEADBEEF; base_ram_addr=1; ext_ram_ce_n stays 1.
REQ-034 Write 0x8040_0000 with be=4'b0001, wdata=0x000000AA over initial contents 0x11223344 -> read returns 0x112233AA.
REQ-035 CPLD sends 0x32 -> status read returns bit1=1; data read at 0xBFD0_03F8 returns 0x00000032 with uart_rdn low for 2 cycles.
REQ-036 Write 0x33 to 0xBFD0_03F8 -> uart_wrn low for 2 cycles with base_ram_data[7:0]=0x33 and base_ram_ce_n=1; CPLD receives 0x33.
REQ-037 Read 0x1234_5678 -> ack after 1 cycle, rdata=0, no strobe toggles.
REQ-038 Assert reset_btn during the 2nd cycle of RAM_WR -> we_n=1, ce_n=1 and bus high-Z next edge; no ack.

Source files
------------

// File: rtl/sram_uart_bus_ctrl_if.sv
// sram_uart_bus_ctrl_if
// CPU-side request/acknowledge bus for sram_uart_bus_ctrl.
//   req   : access request, held high until ack
//   we    : 1 = write, 0 = read
//   addr  : byte address
//   wdata : write data
//   be    : byte enables, active-high, bit0 = bits[7:0]
//   rdata : read data, valid in the ack cycle and held until the next read
//   ack   : one-cycle completion pulse
// modport master : CPU / bus initiator
// modport slave  : sram_uart_bus_ctrl
interface sram_uart_bus_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ack
  );
endinterface

// File: rtl/sram_uart_bus_ctrl.sv
// sram_uart_bus_ctrl
// Bridges a simple req/ack CPU bus onto two asynchronous SRAMs (base, ext)
// and a CPLD UART whose data byte shares base_ram_data[7:0].
// Ports:
//   clk_50M, reset_btn      : clock, synchronous active-high reset
//   bus (slave modport)     : CPU request/ack bus
//   base_ram_* / ext_ram_*  : SRAM data (inout), word address, active-low
//                             byte enables and ce/oe/we strobes
//   uart_rdn, uart_wrn      : active-low UART read/write strobes
//   uart_dataready/tbre/tsre: UART status flags
// Every pin output is a register, so strobes are glitch-free.
module sram_uart_bus_ctrl #(
  parameter int UART_STROBE_CYCLES = 2
) (
  input  logic                 clk_50M,
  input  logic                 reset_btn,
  sram_uart_bus_ctrl_if.slave  bus,

  inout  wire  [31:0]          base_ram_data,
  output logic [19:0]          base_ram_addr,
  output logic [3:0]           base_ram_be_n,
  output logic                 base_ram_ce_n,
  output logic                 base_ram_oe_n,
  output logic                 base_ram_we_n,

  inout  wire  [31:0]          ext_ram_data,
  output logic [19:0]          ext_ram_addr,
  output logic [3:0]           ext_ram_be_n,
  output logic                 ext_ram_ce_n,
  output logic                 ext_ram_oe_n,
  output logic                 ext_ram_we_n,

  output logic                 uart_rdn,
  output logic                 uart_wrn,
  input  logic                 uart_dataready,
  input  logic                 uart_tbre,
  input  logic                 uart_tsre
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RAM_RD  = 3'd1;
  localparam logic [2:0] ST_RAM_WR  = 3'd2;
  localparam logic [2:0] ST_UART_RD = 3'd3;
  localparam logic [2:0] ST_UART_WR = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [2:0] TGT_NONE  = 3'd0;
  localparam logic [2:0] TGT_BASE  = 3'd1;
  localparam logic [2:0] TGT_EXT   = 3'd2;
  localparam logic [2:0] TGT_UDATA = 3'd3;
  localparam logic [2:0] TGT_USTAT = 3'd4;

  // Counter value in the last strobe-low cycle, and in the extra hold cycle
  // of a UART write.
  localparam logic [7:0] STROBE_LAST = 8'(UART_STROBE_CYCLES - 1);
  localparam logic [7:0] STROBE_END  = 8'(UART_STROBE_CYCLES);

  // Address map decode.
  function automatic logic [2:0] decode_target(input logic [31:0] a);
    logic [2:0] t;
    if (a[31:22] == 10'b1000_0000_00)   t = TGT_BASE;
    else if (a[31:22] == 10'b1000_0000_01) t = TGT_EXT;
    else if (a == 32'hBFD0_03F8)        t = TGT_UDATA;
    else if (a == 32'hBFD0_03FC)        t = TGT_USTAT;
    else                                t = TGT_NONE;
    return t;
  endfunction

  logic [2:0]  state_r;
  logic [7:0]  cnt_r;
  logic        ext_sel_r;
  logic        ack_r;
  logic [31:0] rdata_r;
  logic [19:0] ram_addr_r;
  logic [3:0]  ram_be_n_r;
  logic        base_ce_n_r, base_oe_n_r, base_we_n_r;
  logic        ext_ce_n_r,  ext_oe_n_r,  ext_we_n_r;
  logic        uart_rdn_r, uart_wrn_r;
  logic [31:0] dout_r;
  logic        base_drv_r;     // full 32-bit drive of base bus (RAM write)
  logic        base_drv_lo_r;  // low byte only (UART write)
  logic        ext_drv_r;
  logic [2:0]  tgt_s;

  // Decode the current request address.
  always_comb begin
    tgt_s = TGT_NONE;
    tgt_s = decode_target(bus.addr);
  end

  // Access sequencer: state, strobes, bus drive enables and read capture.
  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 8'd0;
      ext_sel_r     <= 1'b0;
      ack_r         <= 1'b0;
      rdata_r       <= 32'd0;
      ram_addr_r    <= 20'd0;
      ram_be_n_r    <= 4'hF;
      base_ce_n_r   <= 1'b1;
      base_oe_n_r   <= 1'b1;
      base_we_n_r   <= 1'b1;
      ext_ce_n_r    <= 1'b1;
      ext_oe_n_r    <= 1'b1;
      ext_we_n_r    <= 1'b1;
      uart_rdn_r    <= 1'b1;
      uart_wrn_r    <= 1'b1;
      dout_r        <= 32'd0;
      base_drv_r    <= 1'b0;
      base_drv_lo_r <= 1'b0;
      ext_drv_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack_r <= 1'b0;
          cnt_r <= 8'd0;
          if (bus.req) begin
            case (tgt_s)
              TGT_BASE, TGT_EXT: begin
                ext_sel_r  <= (tgt_s == TGT_EXT);
                ram_addr_r <= bus.addr[21:2];
                ram_be_n_r <= ~bus.be;
                dout_r     <= bus.wdata;
                // Only the selected chip sees ce_n low; the other stays idle.
                if (tgt_s == TGT_EXT) begin
                  ext_ce_n_r <= 1'b0;
                  ext_oe_n_r <= bus.we;
                  ext_we_n_r <= ~bus.we;
                  ext_drv_r  <= bus.we;
                end else begin
                  base_ce_n_r <= 1'b0;
                  base_oe_n_r <= bus.we;
                  base_we_n_r <= ~bus.we;
                  base_drv_r  <= bus.we;
                end
                state_r <= bus.we ? ST_RAM_WR : ST_RAM_RD;
              end
              TGT_UDATA: begin
                if (bus.we) begin
                  uart_wrn_r    <= 1'b0;
                  base_drv_lo_r <= 1'b1;
                  dout_r        <= {24'd0, bus.wdata[7:0]};
                  state_r       <= ST_UART_WR;
                end else begin
                  uart_rdn_r <= 1'b0;
                  state_r    <= ST_UART_RD;
                end
              end
              TGT_USTAT: begin
                if (bus.we) rdata_r <= 32'd0;
                else        rdata_r <= {30'd0, uart_dataready, uart_tbre & uart_tsre};
                ack_r   <= 1'b1;
                state_r <= ST_DONE;
              end
              default: begin
                rdata_r <= 32'd0;
                ack_r   <= 1'b1;
                state_r <= ST_DONE;
              end
            endcase
          end
        end

        ST_RAM_RD: begin
          if (cnt_r == 8'd1) begin
            rdata_r     <= ext_sel_r ? ext_ram_data : base_ram_data;
            base_ce_n_r <= 1'b1;
            base_oe_n_r <= 1'b1;
            ext_ce_n_r  <= 1'b1;
            ext_oe_n_r  <= 1'b1;
            ack_r       <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end

        ST_RAM_WR: begin
          if (cnt_r == 8'd1) begin
            base_ce_n_r <= 1'b1;
            ext_ce_n_r  <= 1'b1;
            base_drv_r  <= 1'b0;
            ext_drv_r   <= 1'b0;
            ack_r       <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            // we_n rises after one cycle; data and ce_n hold one more cycle.
            base_we_n_r <= 1'b1;
            ext_we_n_r  <= 1'b1;
            cnt_r       <= cnt_r + 8'd1;
          end
        end

        ST_UART_RD: begin
          if (cnt_r == STROBE_LAST) begin
            rdata_r    <= {24'd0, base_ram_data[7:0]};
            uart_rdn_r <= 1'b1;
            ack_r      <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end

        ST_UART_WR: begin
          if (cnt_r == STROBE_END) begin
            base_drv_lo_r <= 1'b0;
            ack_r         <= 1'b1;
            state_r       <= ST_DONE;
          end else begin
            // Data is held one cycle past the rising edge of uart_wrn.
            if (cnt_r == STROBE_LAST) uart_wrn_r <= 1'b1;
            cnt_r <= cnt_r + 8'd1;
          end
        end

        ST_DONE: begin
          ack_r      <= 1'b0;
          ram_be_n_r <= 4'hF;
          state_r    <= ST_IDLE;
        end

        default: begin
          ack_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack   = ack_r;
  assign bus.rdata = rdata_r;

  assign base_ram_addr = ram_addr_r;
  assign base_ram_be_n = ram_be_n_r;
  assign base_ram_ce_n = base_ce_n_r;
  assign base_ram_oe_n = base_oe_n_r;
  assign base_ram_we_n = base_we_n_r;
  assign ext_ram_addr  = ram_addr_r;
  assign ext_ram_be_n  = ram_be_n_r;
  assign ext_ram_ce_n  = ext_ce_n_r;
  assign ext_ram_oe_n  = ext_oe_n_r;
  assign ext_ram_we_n  = ext_we_n_r;
  assign uart_rdn      = uart_rdn_r;
  assign uart_wrn      = uart_wrn_r;

  // The UART byte lane can be driven on its own, so the base bus is split.
  assign base_ram_data[31:8] = base_drv_r ? dout_r[31:8] : 24'bz;
  assign base_ram_data[7:0]  = (base_drv_r | base_drv_lo_r) ? dout_r[7:0] : 8'bz;
  assign ext_ram_data        = ext_drv_r ? dout_r : 32'bz;

endmodule

// File: tb/tb_sram_uart_bus_ctrl.sv
// tb_sram_uart_bus_ctrl
// Directed test of sram_uart_bus_ctrl with behavioural SRAM and UART models.
module tb_sram_uart_bus_ctrl;

  logic clk_50M = 1'b0;
  logic reset_btn;

  sram_uart_bus_ctrl_if bus();

  wire  [31:0] base_ram_data;
  logic [19:0] base_ram_addr;
  logic [3:0]  base_ram_be_n;
  logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
  wire  [31:0] ext_ram_data;
  logic [19:0] ext_ram_addr;
  logic [3:0]  ext_ram_be_n;
  logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
  logic        uart_rdn, uart_wrn;
  logic        uart_dataready, uart_tbre, uart_tsre;
  logic [7:0]  uart_rx_byte;

  sram_uart_bus_ctrl #(.UART_STROBE_CYCLES(2)) dut (
    .clk_50M        (clk_50M),
    .reset_btn      (reset_btn),
    .bus            (bus.slave),
    .base_ram_data  (base_ram_data),
    .base_ram_addr  (base_ram_addr),
    .base_ram_be_n  (base_ram_be_n),
    .base_ram_ce_n  (base_ram_ce_n),
    .base_ram_oe_n  (base_ram_oe_n),
    .base_ram_we_n  (base_ram_we_n),
    .ext_ram_data   (ext_ram_data),
    .ext_ram_addr   (ext_ram_addr),
    .ext_ram_be_n   (ext_ram_be_n),
    .ext_ram_ce_n   (ext_ram_ce_n),
    .ext_ram_oe_n   (ext_ram_oe_n),
    .ext_ram_we_n   (ext_ram_we_n),
    .uart_rdn       (uart_rdn),
    .uart_wrn       (uart_wrn),
    .uart_dataready (uart_dataready),
    .uart_tbre      (uart_tbre),
    .uart_tsre      (uart_tsre)
  );

  // 50 MHz clock.
  always #10 clk_50M = ~clk_50M;

  // 16-word SRAM models (address wraps on the low 4 bits).
  logic [31:0] base_mem [16];
  logic [31:0] ext_mem  [16];
  wire  [31:0] base_word = base_mem[base_ram_addr[3:0]];
  wire  [31:0] ext_word  = ext_mem[ext_ram_addr[3:0]];
  wire         base_rd_en = !base_ram_ce_n && !base_ram_oe_n;
  wire         ext_rd_en  = !ext_ram_ce_n && !ext_ram_oe_n;

  assign base_ram_data[31:8] = base_rd_en ? base_word[31:8] : 24'bz;
  assign base_ram_data[7:0]  = base_rd_en ? base_word[7:0] :
                               (!uart_rdn ? uart_rx_byte : 8'bz);
  assign ext_ram_data        = ext_rd_en ? ext_word : 32'bz;

  // Monitor counters (cycles each signal was low) and last seen values.
  int          rdn_lo = 0, wrn_lo = 0, bce_lo = 0, ece_lo = 0, bwe_lo = 0;
  int          bad_cnt = 0, ack_cnt = 0;
  logic [19:0] last_base_addr = 20'd0;
  logic [19:0] last_ext_addr  = 20'd0;
  logic [7:0]  uart_tx_byte   = 8'd0;

  // SRAM write model plus bus monitors.
  always @(posedge clk_50M) begin
    if (reset_btn) begin
      for (int i = 0; i < 16; i++) begin
        base_mem[i] <= 32'd0;
        ext_mem[i]  <= 32'd0;
      end
      ext_mem[0] <= 32'h1122_3344;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (!base_ram_ce_n && !base_ram_we_n && !base_ram_be_n[b])
          base_mem[base_ram_addr[3:0]][8*b +: 8] <= base_ram_data[8*b +: 8];
        if (!ext_ram_ce_n && !ext_ram_we_n && !ext_ram_be_n[b])
          ext_mem[ext_ram_addr[3:0]][8*b +: 8] <= ext_ram_data[8*b +: 8];
      end
    end
    if (!uart_rdn) rdn_lo++;
    if (!uart_wrn) begin
      wrn_lo++;
      uart_tx_byte = base_ram_data[7:0];
    end
    if (!base_ram_ce_n) begin
      bce_lo++;
      last_base_addr = base_ram_addr;
    end
    if (!ext_ram_ce_n) begin
      ece_lo++;
      last_ext_addr = ext_ram_addr;
    end
    if (!base_ram_ce_n && !base_ram_we_n) bwe_lo++;
    if ((!uart_rdn && !uart_wrn) || ((!uart_rdn || !uart_wrn) && !base_ram_ce_n))
      bad_cnt++;
    if (bus.ack) ack_cnt++;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Per-operation deltas of the monitor counters.
  int d_rdn, d_wrn, d_bce, d_ece, d_bwe, d_bad;

  // One bus transaction: checks latency and the single-cycle ack pulse.
  task automatic run_op(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input int exp_lat, output logic [31:0] rd);
    int s_rdn, s_wrn, s_bce, s_ece, s_bwe, s_bad, lat;
    bit got;
    s_rdn = rdn_lo; s_wrn = wrn_lo; s_bce = bce_lo;
    s_ece = ece_lo; s_bwe = bwe_lo; s_bad = bad_cnt;
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.be = b;
    lat = 0;
    got = 1'b0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(posedge clk_50M); #1;
      if (bus.ack) begin
        got = 1'b1;
        lat = n;
      end
    end
    rd = bus.rdata;
    bus.req = 1'b0;
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    @(posedge clk_50M); #1;
    check_val({tag, "_ackpulse"}, {31'd0, bus.ack}, 32'd0);
    d_rdn = rdn_lo - s_rdn; d_wrn = wrn_lo - s_wrn; d_bce = bce_lo - s_bce;
    d_ece = ece_lo - s_ece; d_bwe = bwe_lo - s_bwe; d_bad = bad_cnt - s_bad;
  endtask

  logic [31:0] rd;
  int          ack_snap;

  // Directed stimulus.
  initial begin
    reset_btn = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0; bus.be = 4'h0;
    uart_dataready = 1'b0; uart_tbre = 1'b0; uart_tsre = 1'b0; uart_rx_byte = 8'h00;
    repeat (3) @(posedge clk_50M);
    #1;
    check_val("rst_ctrl", {16'd0, base_ram_ce_n, base_ram_oe_n, base_ram_we_n,
                           ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n, uart_rdn, uart_wrn,
                           base_ram_be_n, ext_ram_be_n}, 32'h0000_FFFF);
    check_val("rst_ack", {31'd0, bus.ack}, 32'd0);
    check_val("rst_rdata", bus.rdata, 32'd0);
    reset_btn = 1'b0;
    @(posedge clk_50M); #1;

    // Base RAM full-word write then read.
    run_op("base_wr", 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 3, rd);
    check_val("base_wr_ext_ce", 32'(d_ece), 32'd0);
    check_val("base_wr_we_cycles", 32'(d_bwe), 32'd1);
    check_val("base_wr_ce_cycles", 32'(d_bce), 32'd2);
    check_val("base_wr_addr", {12'd0, last_base_addr}, 32'd1);
    check_val("base_mem1", base_mem[1], 32'hDEAD_BEEF);
    run_op("base_rd", 1'b0, 32'h8000_0004, 32'd0, 4'hF, 3, rd);
    check_val("base_rd_data", rd, 32'hDEAD_BEEF);
    check_val("base_rd_ext_ce", 32'(d_ece), 32'd0);
    check_val("base_rd_addr", {12'd0, last_base_addr}, 32'd1);

    // Ext RAM single-byte write over preset contents.
    run_op("ext_wr_b0", 1'b1, 32'h8040_0000, 32'h0000_00AA, 4'b0001, 3, rd);
    check_val("ext_wr_base_ce", 32'(d_bce), 32'd0);
    run_op("ext_rd", 1'b0, 32'h8040_0000, 32'd0, 4'hF, 3, rd);
    check_val("ext_rd_data", rd, 32'h1122_33AA);

    // Top word of each RAM window.
    run_op("base_top_wr", 1'b1, 32'h803F_FFFC, 32'h0BAD_F00D, 4'hF, 3, rd);
    check_val("base_top_ext_ce", 32'(d_ece), 32'd0);
    check_val("base_top_addr", {12'd0, last_base_addr}, 32'h000F_FFFF);
    run_op("base_top_rd", 1'b0, 32'h803F_FFFC, 32'd0, 4'hF, 3, rd);
    check_val("base_top_data", rd, 32'h0BAD_F00D);
    run_op("ext_top_wr", 1'b1, 32'h807F_FFFC, 32'hCAFE_1234, 4'hF, 3, rd);
    check_val("ext_top_base_ce", 32'(d_bce), 32'd0);
    check_val("ext_top_addr", {12'd0, last_ext_addr}, 32'h000F_FFFF);
    run_op("ext_top_rd", 1'b0, 32'h807F_FFFC, 32'd0, 4'hF, 3, rd);
    check_val("ext_top_data", rd, 32'hCAFE_1234);

    // UART status and data read (CPLD has received 0x32).
    uart_dataready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b0; uart_rx_byte = 8'h32;
    run_op("stat_rd0", 1'b0, 32'hBFD0_03FC, 32'd0, 4'hF, 1, rd);
    check_val("stat_rd0_data", rd, 32'h0000_0002);
    check_val("stat_rd0_rdn", 32'(d_rdn), 32'd0);
    run_op("uart_rd", 1'b0, 32'hBFD0_03F8, 32'd0, 4'hF, 3, rd);
    check_val("uart_rd_data", rd, 32'h0000_0032);
    check_val("uart_rd_rdn_cycles", 32'(d_rdn), 32'd2);
    check_val("uart_rd_base_ce", 32'(d_bce), 32'd0);
    check_val("uart_rd_overlap", 32'(d_bad), 32'd0);
    uart_tsre = 1'b1;
    run_op("stat_rd1", 1'b0, 32'hBFD0_03FC, 32'd0, 4'hF, 1, rd);
    check_val("stat_rd1_data", rd, 32'h0000_0003);

    // UART write: only the low byte goes out; rdata keeps the last read.
    run_op("uart_wr", 1'b1, 32'hBFD0_03F8, 32'hFFFF_FF33, 4'hF, 4, rd);
    check_val("uart_wr_wrn_cycles", 32'(d_wrn), 32'd2);
    check_val("uart_wr_tx_byte", {24'd0, uart_tx_byte}, 32'h0000_0033);
    check_val("uart_wr_base_ce", 32'(d_bce), 32'd0);
    check_val("uart_wr_overlap", 32'(d_bad), 32'd0);
    check_val("uart_wr_rdata_hold", rd, 32'h0000_0003);

    // Unmapped accesses and a status write complete in one cycle, quietly.
    run_op("unmap_rd", 1'b0, 32'h1234_5678, 32'd0, 4'hF, 1, rd);
    check_val("unmap_rd_data", rd, 32'd0);
    check_val("unmap_rd_strobes", 32'(d_rdn + d_wrn), 32'd0);
    check_val("unmap_rd_ce", 32'(d_bce + d_ece), 32'd0);
    run_op("unmap_hi", 1'b0, 32'h8080_0000, 32'd0, 4'hF, 1, rd);
    check_val("unmap_hi_ce", 32'(d_bce + d_ece), 32'd0);
    run_op("stat_wr", 1'b1, 32'hBFD0_03FC, 32'h0000_00FF, 4'hF, 1, rd);
    check_val("stat_wr_strobes", 32'(d_rdn + d_wrn), 32'd0);

    // Reset during the 2nd cycle of a RAM write aborts it without an ack.
    ack_snap = ack_cnt;
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h8000_0008;
    bus.wdata = 32'h5555_AAAA; bus.be = 4'hF;
    @(posedge clk_50M); #1;
    check_val("abort_c1_we", {31'd0, base_ram_we_n}, 32'd0);
    @(posedge clk_50M); #1;
    check_val("abort_c2_ce", {30'd0, base_ram_ce_n, base_ram_we_n}, 32'h0000_0001);
    reset_btn = 1'b1;
    @(posedge clk_50M); #1;
    check_val("abort_ctrl", {29'd0, base_ram_ce_n, base_ram_we_n, bus.ack}, 32'h0000_0006);
    bus.req = 1'b0;
    reset_btn = 1'b0;
    repeat (3) @(posedge clk_50M);
    #1;
    check_val("abort_no_ack", 32'(ack_cnt - ack_snap), 32'd0);
    run_op("post_abort_rd", 1'b0, 32'h8000_0004, 32'd0, 4'hF, 3, rd);
    check_val("post_abort_data", rd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
